uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
- Buffered UART transmitter: the serialising end of the team's UART link, driving the line that uart_rx samples.
- Accepts parallel words over a valid/ready handshake into a small FIFO.
- Emits frames as: 1 start bit (low), DATA_BITS data bits MSB first, STOP_BITS stop bits (high). No parity.
- MSB-first order matches uart_rx, which fills data_out from bit DATA_BITS-1 down to bit 0.

Parameters:
- DATA_BITS, 8: data bits per frame; must be >=1.
- STOP_BITS, 1: stop bits per frame; must be >=1.
- CLKS_PER_BIT, 1000: clk cycles per bit period; must be >=2.
- FIFO_DEPTH, 4: input FIFO entries; must be a power of 2 and >=2.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- resetn  input  1  synchronous, active-low reset.
- in_valid  input  1  in_data holds a word to send.
- in_ready  output  1  FIFO can accept a word this cycle.
- in_data  input  DATA_BITS  word to transmit.
- data_out  output  1  serial line; idles high; registered.
- busy  output  1  high while a frame is in flight or the FIFO is non-empty.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (edge with resetn=0):
  - data_out=1, state=IDLE, FIFO cleared, fifo_count=0, busy=0, all counters 0.
  - in_ready is forced 0 combinationally while resetn=0.
- Handshake:
  - in_ready = (fifo_count != FIFO_DEPTH) AND resetn. It never depends on in_valid.
  - A word is accepted on an edge where in_valid && in_ready.
  - in_data is ignored when in_ready=0; no overwrite, no corruption.
- FIFO:
  - Circular buffer with wrapping read/write pointers.
  - A push and a pop on the same edge leave fifo_count unchanged.
  - Pop occurs only when non-empty; push occurs only when not full.
- State machine (registered data_out, shift register, bit counter, clock counter 0..CLKS_PER_BIT-1):
  - IDLE: data_out=1. If FIFO non-empty at an edge: pop the head into the shift register, set data_out=0, go to START, clock counter=0.
  - START: after CLKS_PER_BIT cycles, drive shreg MSB, go to DATA, bit counter=DATA_BITS-1.
  - DATA: each CLKS_PER_BIT cycles, shift left and drive the next bit. After the LSB period: data_out=1, go to STOP, bit counter=STOP_BITS-1.
  - STOP: line held high for STOP_BITS*CLKS_PER_BIT cycles. At the end of the last stop period:
    - if FIFO non-empty, pop and set data_out=0 (START) on that same edge, with zero idle gap;
    - else go to IDLE.
- Latency: word accepted at edge E into an empty FIFO with the FSM in IDLE -> start bit driven from edge E+1.
- Frame length: exactly (1+DATA_BITS+STOP_BITS)*CLKS_PER_BIT cycles. Every bit period is exactly CLKS_PER_BIT cycles.
- busy = (state != IDLE) || (fifo_count != 0).
- Reset mid-frame: the frame is abandoned, data_out goes high on that edge, and FIFO contents are discarded.
- Counter widths: clock counter $clog2(CLKS_PER_BIT); bit counter sized for max(DATA_BITS, STOP_BITS). No overflow wrap is permitted outside the ranges stated.

Test Plan:
Common parameters: DATA_BITS=8, STOP_BITS=1, CLKS_PER_BIT=16, FIFO_DEPTH=4 unless stated.
- Single word: push 0xA5 into idle block -> data_out low 16 cycles, then 1,0,1,0,0,1,0,1 for 16 cycles each, then high 16 cycles. Frame is 160 cycles starting 1 edge after acceptance. busy drops on the edge the stop bit ends, fifo_count back to 0.
- Loopback: data_out feeds uart_rx with the same parameters; send 0x00, 0xFF, 0x5A, 0x81 -> uart_rx pulses valid four times with identical values in order.
- Backpressure: hold in_valid high with words 1..6 from reset release -> words 1-5 are accepted (word 1 is popped immediately). in_ready stays low until frame 1 ends, then word 6 is accepted. Six frames are transmitted contiguously: 960 cycles, no idle-high gap between frames.
- Stall robustness: change in_data while in_ready=0 -> transmitted sequence contains only accepted words, unchanged.
- Reset mid-frame: assert resetn=0 for 1 cycle at cycle 50 of a frame -> data_out=1, fifo_count=0, busy=0 next cycle. A new word 0x3C then produces a complete, correct 160-cycle frame.
- STOP_BITS=2 variant: send 0x01 -> stop high for 32 cycles, frame is 176 cycles; uart_rx with STOP_BITS=2 reports valid with 0x01.

Source files
------------

// File: rtl/uart_tx_if.sv
// Parallel word handshake into the UART transmitter.
interface uart_tx_if #(
  parameter int DATA_BITS = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [DATA_BITS-1:0] in_data;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/uart_tx.sv
// Buffered UART transmitter: FIFO-fed, 1 start bit, MSB-first data, STOP_BITS stop bits.
module uart_tx #(
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 1000,
  parameter int FIFO_DEPTH   = 4
)(
  input  logic                        clk,
  input  logic                        resetn,
  uart_tx_if.slave                    s_in,
  output logic                        data_out,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int BMAX = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
  localparam int BW   = (BMAX > 1) ? $clog2(BMAX) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               r_state, w_state_nxt;
  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wr_ptr, r_rd_ptr;
  logic [AW:0]          r_count;
  logic [DATA_BITS-1:0] r_shreg, w_shreg_nxt, w_shreg_sh;
  logic [CW-1:0]        r_clk_cnt, w_clk_cnt_nxt;
  logic [BW-1:0]        r_bit_cnt, w_bit_cnt_nxt;
  logic                 r_data_out, w_data_out_nxt;
  logic                 w_push, w_pop, w_empty, w_tick, w_last;
  logic [DATA_BITS-1:0] w_head;

  assign s_in.in_ready = (r_count != (AW+1)'(FIFO_DEPTH)) && resetn;
  assign w_push        = s_in.in_valid && s_in.in_ready;
  assign w_empty       = (r_count == '0);
  assign w_head        = r_mem[r_rd_ptr];
  assign w_tick        = (r_clk_cnt == CW'(CLKS_PER_BIT - 1));
  assign w_last        = (r_bit_cnt == '0);
  assign w_shreg_sh    = r_shreg << 1;

  assign data_out   = r_data_out;
  assign fifo_count = r_count;
  assign busy       = (r_state != IDLE) || !w_empty;

  // FIFO storage; no reset needed since the pointers define validity
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= s_in.in_data;
  end

  // FIFO pointers and occupancy; simultaneous push+pop leaves count unchanged
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  // FSM next state; a non-empty FIFO at the end of STOP chains straight into START
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (!w_empty) w_state_nxt = START;
      START:   if (w_tick) w_state_nxt = DATA;
      DATA:    if (w_tick && w_last) w_state_nxt = STOP;
      STOP:    if (w_tick && w_last) w_state_nxt = w_empty ? IDLE : START;
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM datapath: line level, shifter, counters and FIFO pop for the next edge
  always_comb begin
    w_pop          = 1'b0;
    w_shreg_nxt    = r_shreg;
    w_clk_cnt_nxt  = w_tick ? '0 : r_clk_cnt + CW'(1);
    w_bit_cnt_nxt  = r_bit_cnt;
    w_data_out_nxt = r_data_out;
    case (r_state)
      IDLE: begin
        w_clk_cnt_nxt  = '0;
        w_data_out_nxt = 1'b1;
        if (!w_empty) begin
          w_pop          = 1'b1;
          w_shreg_nxt    = w_head;
          w_data_out_nxt = 1'b0;
        end
      end
      START: if (w_tick) begin
        w_data_out_nxt = r_shreg[DATA_BITS-1];
        w_bit_cnt_nxt  = BW'(DATA_BITS - 1);
      end
      DATA: if (w_tick) begin
        if (w_last) begin
          w_data_out_nxt = 1'b1;
          w_bit_cnt_nxt  = BW'(STOP_BITS - 1);
        end else begin
          w_shreg_nxt    = w_shreg_sh;
          w_data_out_nxt = w_shreg_sh[DATA_BITS-1];
          w_bit_cnt_nxt  = r_bit_cnt - BW'(1);
        end
      end
      STOP: if (w_tick) begin
        if (!w_last) begin
          w_bit_cnt_nxt = r_bit_cnt - BW'(1);
        end else if (!w_empty) begin
          w_pop          = 1'b1;
          w_shreg_nxt    = w_head;
          w_data_out_nxt = 1'b0;
        end
      end
      default: w_data_out_nxt = 1'b1;
    endcase
  end

  // Datapath registers; reset abandons any frame and idles the line high
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_shreg    <= '0;
      r_clk_cnt  <= '0;
      r_bit_cnt  <= '0;
      r_data_out <= 1'b1;
    end else begin
      r_shreg    <= w_shreg_nxt;
      r_clk_cnt  <= w_clk_cnt_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_data_out <= w_data_out_nxt;
    end
  end
endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: scoreboarded frame decoder plus directed timing checks.
module tb_uart_tx;
  localparam int DB = 8, CPB = 16, FD = 4;

  typedef struct { logic [7:0] d; int c; } exp_t;

  logic clk = 1'b0, resetn = 1'b0;
  always #5 clk = ~clk;

  uart_tx_if #(.DATA_BITS(DB)) if0();
  uart_tx_if #(.DATA_BITS(DB)) if1();
  logic       d0, b0, d1, b1;
  logic [2:0] c0, c1;

  uart_tx #(.DATA_BITS(DB), .STOP_BITS(1), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(FD)) u0 (
    .clk(clk), .resetn(resetn), .s_in(if0), .data_out(d0), .busy(b0), .fifo_count(c0));
  uart_tx #(.DATA_BITS(DB), .STOP_BITS(2), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(FD)) u1 (
    .clk(clk), .resetn(resetn), .s_in(if1), .data_out(d1), .busy(b1), .fifo_count(c1));

  exp_t q0[$], q1[$];
  int   acc_log[$], starts0[$];
  int   cyc_n = 0;
  int   n_pass = 0, n_tot = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Scoreboard push: every accepted word with the edge number that took it
  always @(posedge clk) begin
    cyc_n <= cyc_n + 1;
    if (resetn && if0.in_valid && if0.in_ready) begin
      q0.push_back('{d: if0.in_data, c: cyc_n + 1});
      acc_log.push_back(cyc_n + 1);
    end
    if (resetn && if1.in_valid && if1.in_ready)
      q1.push_back('{d: if1.in_data, c: cyc_n + 1});
  end

  function automatic logic exp_bit(input logic [7:0] d, input int c);
    int bi;
    bi = c / CPB;
    if (bi == 0) return 1'b0;
    if (bi <= DB) return d[DB-bi];
    return 1'b1;
  endfunction

  // Frame decoder: checks every cycle of a frame against the expected word
  task automatic mon(input int sel);
    int sb, fl, cyc, bad;
    bit act;
    logic ln;
    logic [7:0] rx;
    exp_t e;
    sb = sel ? 2 : 1;
    fl = (1 + DB + sb) * CPB;
    act = 0; cyc = 0; bad = 0; rx = '0; e = '{d: 8'h00, c: 0};
    forever begin
      @(negedge clk);
      ln = sel ? d1 : d0;
      if (!resetn) begin act = 0; continue; end
      if (act) begin
        cyc++;
        if (cyc == fl) begin
          act = 0;
          chk(sel ? "rx1_data" : "rx0_data", {24'h0, rx}, {24'h0, e.d});
          chk(sel ? "rx1_badcycles" : "rx0_badcycles", bad, 0);
        end else begin
          if (ln !== exp_bit(e.d, cyc)) bad++;
          if (cyc % CPB == CPB/2 && cyc/CPB >= 1 && cyc/CPB <= DB) rx = {rx[6:0], ln};
        end
      end
      if (!act && ln === 1'b0) begin
        if (sel ? (q1.size() == 0) : (q0.size() == 0)) begin
          chk(sel ? "unexpected_frame1" : "unexpected_frame0", 0, 1);
          e = '{d: 8'h00, c: 0};
        end else e = sel ? q1.pop_front() : q0.pop_front();
        act = 1; cyc = 0; bad = 0; rx = '0;
        if (!sel) starts0.push_back(cyc_n);
      end
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_idle(input int sel, input int maxc);
    int k = 0;
    while (k < maxc && !(sel ? (q1.size() == 0 && !b1) : (q0.size() == 0 && !b0))) begin
      tick(); k++;
    end
    chk(sel ? "idle_timeout1" : "idle_timeout0", k < maxc, 1);
    tick(3);
  endtask

  task automatic check_contig(input string tag, input int n);
    chk(tag, starts0.size(), n);
    for (int i = 1; i < starts0.size(); i++)
      chk("frame_gap", starts0[i] - starts0[i-1], (1 + DB + 1) * CPB);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc, w, guard;
    logic [7:0] words [4];
    words[0] = 8'h00; words[1] = 8'hFF; words[2] = 8'h5A; words[3] = 8'h81;
    if0.in_valid = 1'b0; if0.in_data = '0;
    if1.in_valid = 1'b0; if1.in_data = '0;
    fork mon(0); mon(1); join_none

    // reset state
    tick(3);
    chk("rst_dout", d0, 1);
    chk("rst_busy", b0, 0);
    chk("rst_count", c0, 0);
    chk("rst_ready", if0.in_ready, 0);
    resetn = 1'b1; #1;
    chk("ready_after_rst", if0.in_ready, 1);
    tick();

    // single word 0xA5: latency, frame length, busy drop
    if0.in_valid = 1'b1; if0.in_data = 8'hA5;
    tick();
    if0.in_valid = 1'b0;
    chk("t1_accepted", acc_log.size(), 1);
    acc = acc_log[0];
    tick();
    chk("t1_start_low", d0, 0);
    chk("t1_count_popped", c0, 0);
    chk("t1_busy", b0, 1);
    tick(159);
    chk("t1_busy_last_stop", b0, 1);
    chk("t1_stop_high", d0, 1);
    tick();
    chk("t1_busy_drop", b0, 0);
    chk("t1_count_end", c0, 0);
    tick(3);
    chk("t1_latency", starts0[0] - acc, 1);
    starts0.delete(); acc_log.delete();

    // loopback-style four words, back to back
    for (int i = 0; i < 4; i++) begin
      if0.in_valid = 1'b1; if0.in_data = words[i];
      tick();
    end
    if0.in_valid = 1'b0;
    wait_idle(0, 2000);
    check_contig("lb_frames", 4);
    starts0.delete(); acc_log.delete();

    // backpressure with garbage data while stalled
    resetn = 1'b0; tick(2);
    q0.delete(); starts0.delete(); acc_log.delete();
    if0.in_valid = 1'b1; if0.in_data = 8'd1; resetn = 1'b1;
    guard = 0; w = 1;
    while (w <= 6 && guard < 400) begin
      tick(); guard++;
      w = acc_log.size() + 1;
      if (w <= 6) if0.in_data = if0.in_ready ? 8'(w) : (8'hE0 | 8'(guard & 15));
    end
    if0.in_valid = 1'b0;
    chk("bp_accepted", acc_log.size(), 6);
    if (acc_log.size() == 6) begin
      chk("bp_w5_edge", acc_log[4] - acc_log[0], 4);
      chk("bp_w6_edge", acc_log[5] - acc_log[0], 162);
    end
    wait_idle(0, 2000);
    check_contig("bp_frames", 6);
    starts0.delete(); acc_log.delete();

    // reset mid-frame discards frame and queued word
    if0.in_valid = 1'b1; if0.in_data = 8'h77; tick();
    if0.in_data = 8'h12; tick();
    if0.in_valid = 1'b0;
    tick(48);
    chk("mid_pre_busy", b0, 1);
    resetn = 1'b0; #1;
    chk("mid_ready_rst", if0.in_ready, 0);
    tick();
    chk("mid_dout", d0, 1);
    chk("mid_count", c0, 0);
    chk("mid_busy", b0, 0);
    q0.delete(); resetn = 1'b1; tick(); starts0.delete();
    if0.in_valid = 1'b1; if0.in_data = 8'h3C; tick();
    if0.in_valid = 1'b0;
    wait_idle(0, 1000);
    tick(200);
    chk("mid_one_frame", starts0.size(), 1);

    // STOP_BITS=2 instance
    if1.in_valid = 1'b1; if1.in_data = 8'h01; tick();
    if1.in_valid = 1'b0;
    tick();
    chk("sb2_start", d1, 0);
    tick(143);
    chk("sb2_last_data", d1, 1);
    tick();
    chk("sb2_stop", d1, 1);
    tick(31);
    chk("sb2_busy_last", b1, 1);
    tick();
    chk("sb2_busy_drop", b1, 0);
    wait_idle(1, 500);

    tick(5);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
